// File: rtl/uninasoc_gpio_irq.sv
// uninasoc_gpio_irq
// -----------------------------------------------------------------------------
// GPIO peripheral with NUM_GPIO_IN synchronised inputs and NUM_GPIO_OUT outputs.
// Each input has programmable edge detection (rising or falling), a sticky
// interrupt status bit (write-1-to-clear) and an enable. The enabled status
// bits are OR-reduced into one registered level interrupt.
//
// Register map (byte offsets, addr_i[1:0] ignored):
//   0x00 IN         RO   synchronised input pins
//   0x04 OUT        RW   output pins
//   0x08 OUT_SET    WO   OUT |= wdata
//   0x0C OUT_CLR    WO   OUT &= ~wdata
//   0x10 IRQ_EN     RW   per-pin interrupt enable
//   0x14 IRQ_RISE   RW   per-pin edge select, 1 = rising, 0 = falling
//   0x18 IRQ_STATUS RW1C sticky edge-detected flags
//   >= 0x1C              unmapped: read data 0, err_o = 1, no state change
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   req_i, we_i          access request, 1 = write / 0 = read
//   addr_i, wdata_i      byte address and write data
//   gnt_o                grant (combinationally equal to req_i)
//   rvalid_o             response strobe, one cycle after each accepted request
//   rdata_o, err_o       read data and unmapped-access flag, valid with rvalid_o
//   gpio_in_i            asynchronous input pins
//   gpio_out_o           output pins (OUT register)
//   irq_o                registered level interrupt
//
// Bus handshake: a request is accepted in every cycle where req_i is high
// (gnt_o mirrors req_i, so there is no back-pressure). Exactly one response
// follows in the next cycle with rvalid_o high, for reads and writes alike;
// rdata_o/err_o are only meaningful while rvalid_o is high. Back-to-back
// requests produce back-to-back responses. A reset between request and
// response discards the response.
// -----------------------------------------------------------------------------
module uninasoc_gpio_irq #(
   parameter int NUM_GPIO_IN  = 8,
   parameter int NUM_GPIO_OUT = 8,
   parameter int SYNC_STAGES  = 2,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5
) (
   input  logic                                            clk_i,
   input  logic                                            rst_i,
   input  logic                                            req_i,
   input  logic                                            we_i,
   input  logic [ADDR_WIDTH-1:0]                           addr_i,
   input  logic [DATA_WIDTH-1:0]                           wdata_i,
   output logic                                            gnt_o,
   output logic                                            rvalid_o,
   output logic [DATA_WIDTH-1:0]                           rdata_o,
   output logic                                            err_o,
   input  logic [((NUM_GPIO_IN > 0) ? NUM_GPIO_IN : 1)-1:0]   gpio_in_i,
   output logic [((NUM_GPIO_OUT > 0) ? NUM_GPIO_OUT : 1)-1:0] gpio_out_o,
   output logic                                            irq_o
);

   localparam int IN_W  = (NUM_GPIO_IN  > 0) ? NUM_GPIO_IN  : 1;
   localparam int OUT_W = (NUM_GPIO_OUT > 0) ? NUM_GPIO_OUT : 1;

   // With zero pins the single spare bit is masked to 0 everywhere, so
   // the corresponding flops are constant and disappear in synthesis.
   localparam logic [IN_W-1:0]  IN_MASK  = (NUM_GPIO_IN  > 0) ? {IN_W{1'b1}}  : {IN_W{1'b0}};
   localparam logic [OUT_W-1:0] OUT_MASK = (NUM_GPIO_OUT > 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

   localparam logic [ADDR_WIDTH-1:0] OFF_IN     = ADDR_WIDTH'(32'h00);
   localparam logic [ADDR_WIDTH-1:0] OFF_OUT    = ADDR_WIDTH'(32'h04);
   localparam logic [ADDR_WIDTH-1:0] OFF_SET    = ADDR_WIDTH'(32'h08);
   localparam logic [ADDR_WIDTH-1:0] OFF_CLR    = ADDR_WIDTH'(32'h0C);
   localparam logic [ADDR_WIDTH-1:0] OFF_EN     = ADDR_WIDTH'(32'h10);
   localparam logic [ADDR_WIDTH-1:0] OFF_RISE   = ADDR_WIDTH'(32'h14);
   localparam logic [ADDR_WIDTH-1:0] OFF_STATUS = ADDR_WIDTH'(32'h18);

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   logic [ADDR_WIDTH-1:0] word_addr;
   logic                  mapped;
   logic                  wr;
   logic [IN_W-1:0]       wd_in;
   logic [OUT_W-1:0]      wd_out;
   logic                  unused_bits;

   assign word_addr   = {addr_i[ADDR_WIDTH-1:2], 2'b00};
   assign mapped      = (word_addr <= OFF_STATUS);
   assign wr          = req_i & we_i & mapped;
   assign wd_in       = wdata_i[IN_W-1:0] & IN_MASK;
   assign wd_out      = wdata_i[OUT_W-1:0] & OUT_MASK;
   assign unused_bits = ^{addr_i[1:0], wdata_i};
   assign gnt_o       = req_i;

   // ---------------------------------------------------------------------------
   // Input synchroniser and previous-value flop
   // ---------------------------------------------------------------------------
   logic [IN_W-1:0] sync_q [SYNC_STAGES];
   logic [IN_W-1:0] in_sync;
   logic [IN_W-1:0] prev_q;

   assign in_sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= gpio_in_i & IN_MASK;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= in_sync;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   logic [OUT_W-1:0] out_q;
   logic [IN_W-1:0]  irq_en;
   logic [IN_W-1:0]  irq_rise;
   logic [IN_W-1:0]  irq_status;
   logic [IN_W-1:0]  edge_det;
   logic [IN_W-1:0]  w1c;
   logic [IN_W-1:0]  status_next;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_q    <= '0;
         irq_en   <= '0;
         irq_rise <= '0;
      end else if (wr) begin
         case (word_addr)
            OFF_OUT:  out_q    <= wd_out;
            OFF_SET:  out_q    <= out_q | wd_out;
            OFF_CLR:  out_q    <= out_q & ~wd_out;
            OFF_EN:   irq_en   <= wd_in;
            OFF_RISE: irq_rise <= wd_in;
            default:  ;
         endcase
      end
   end

   // Edge select is per pin; prev is not touched when IRQ_RISE changes.
   assign edge_det = (irq_rise & in_sync & ~prev_q) | (~irq_rise & ~in_sync & prev_q);

   always_comb begin
      w1c = '0;
      if (wr && (word_addr == OFF_STATUS)) w1c = wd_in;
   end

   // A new edge overrides a simultaneous W1C so the event is never lost.
   assign status_next = (edge_det | (irq_status & ~w1c)) & IN_MASK;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         irq_status <= '0;
         irq_o      <= 1'b0;
      end else begin
         irq_status <= status_next;
         irq_o      <= |(irq_status & irq_en);
      end
   end

   assign gpio_out_o = out_q;

   // ---------------------------------------------------------------------------
   // Read mux and response register
   // ---------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] rdata_next;

   always_comb begin
      rdata_next = '0;
      case (word_addr)
         OFF_IN:     rdata_next = DATA_WIDTH'(in_sync);
         OFF_OUT:    rdata_next = DATA_WIDTH'(out_q);
         OFF_EN:     rdata_next = DATA_WIDTH'(irq_en);
         OFF_RISE:   rdata_next = DATA_WIDTH'(irq_rise);
         OFF_STATUS: rdata_next = DATA_WIDTH'(irq_status);
         default:    rdata_next = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rvalid_o <= 1'b0;
         rdata_o  <= '0;
         err_o    <= 1'b0;
      end else begin
         rvalid_o <= req_i;
         rdata_o  <= req_i ? rdata_next : '0;
         err_o    <= req_i & ~mapped;
      end
   end

endmodule
